// File: rtl/fuzz_bench_pkg.sv
// Shared definitions for the fuzz bench response stage.
// Holds the default signature width, the default MISR polynomial and seed,
// and the run-control FSM state encoding.
package fuzz_bench_pkg;

  localparam int          SIG_W    = 32;
  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WARMUP  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/misr_fold_step.sv
// Combinational MISR next-state function.
// Zero-pads the input bus to a multiple of SIG_W and XORs all SIG_W-wide
// chunks into one fold word. That word is then injected into a Galois-style
// shift of the current signature.
//   y_i        : WIDTH-bit sample bus
//   sig_i      : current signature
//   fold_o     : XOR of all padded chunks of y_i
//   sig_next_o : signature after one MISR step with y_i
module misr_fold_step #(
  parameter int               WIDTH = 81,
  parameter int               SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7
) (
  input  logic [WIDTH-1:0] y_i,
  input  logic [SIG_W-1:0] sig_i,
  output logic [SIG_W-1:0] fold_o,
  output logic [SIG_W-1:0] sig_next_o
);

  localparam int NCH = (WIDTH + SIG_W - 1) / SIG_W;
  localparam int PAD = NCH * SIG_W;

  logic [PAD-1:0] ypad;

  always_comb begin
    ypad             = '0;
    ypad[WIDTH-1:0]  = y_i;
    fold_o           = '0;
    for (int i = 0; i < NCH; i++) fold_o ^= ypad[i*SIG_W +: SIG_W];
  end

  // The MSB shifted out selects whether the polynomial is fed back.
  assign sig_next_o = {sig_i[SIG_W-2:0], 1'b0}
                    ^ (sig_i[SIG_W-1] ? POLY : '0)
                    ^ fold_o;

endmodule

// File: rtl/resp_misr_compactor.sv
// Response compactor: folds the DUT output bus into a MISR signature over a
// fixed number of valid samples so one final word decides equivalence.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a run (honoured in IDLE and DONE only)
//   y_valid, y : sample strobe and DUT output bus
//   sig        : current signature
//   sample_cnt : samples compacted in this run (saturates at N_SAMPLES)
//   busy       : run in progress (WARMUP or CAPTURE)
//   done       : signature is final
//   x_seen     : sticky flag, an accepted capture sample carried X/Z
module resp_misr_compactor
  import fuzz_bench_pkg::*;
#(
  parameter int               WIDTH     = 81,
  parameter int               SIG_W     = fuzz_bench_pkg::SIG_W,
  parameter logic [SIG_W-1:0] POLY      = fuzz_bench_pkg::DEF_POLY,
  parameter logic [SIG_W-1:0] SEED      = fuzz_bench_pkg::DEF_SEED,
  parameter int               SKIP      = 1,
  parameter int               N_SAMPLES = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             y_valid,
  input  logic [WIDTH-1:0] y,
  output logic [SIG_W-1:0] sig,
  output logic [15:0]      sample_cnt,
  output logic             busy,
  output logic             done,
  output logic             x_seen
);

  localparam logic [15:0] SKIP16 = 16'(SKIP);
  localparam logic [15:0] N16    = 16'(N_SAMPLES);

  state_e           state_q;
  logic [SIG_W-1:0] sig_q, sig_d, fold;
  logic [15:0]      cnt_q, skip_q;
  logic             busy_q, done_q, x_q;
  logic             y_is_x;

  misr_fold_step #(.WIDTH(WIDTH), .SIG_W(SIG_W), .POLY(POLY)) u_step (
    .y_i        (y),
    .sig_i      (sig_q),
    .fold_o     (fold),
    .sig_next_o (sig_d)
  );

  // Four-state check only; synthesis reduces the case-equality to 0.
  assign y_is_x = ((^y) === 1'bx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      skip_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) begin
          sig_q   <= SEED;
          cnt_q   <= '0;
          x_q     <= 1'b0;
          skip_q  <= SKIP16;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
          state_q <= (SKIP == 0) ? S_CAPTURE : S_WARMUP;
        end
        S_WARMUP: if (y_valid) begin
          skip_q <= skip_q - 16'd1;
          if (skip_q <= 16'd1) state_q <= S_CAPTURE;
        end
        S_CAPTURE: if (y_valid) begin
          sig_q <= sig_d;
          if (cnt_q != N16) cnt_q <= cnt_q + 16'd1;
          if (y_is_x)       x_q   <= 1'b1;
          // This step brings the count to N_SAMPLES: the run is complete.
          if (cnt_q + 16'd1 >= N16) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sig        = sig_q;
  assign sample_cnt = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign x_seen     = x_q;

endmodule

// File: doc/resp_misr_compactor.md
Name: resp_misr_compactor

Overview:
- Downstream response stage for the fuzz simulation benches.
- Consumes the wide output bus `y` of the design under test (synthesised or reference netlist) once per clock and compacts it into a signature with a multiple-input signature register (MISR).
- Equivalence is judged by comparing one final signature per run, not per-cycle strobed dumps.
- Also flags any X/Z seen on the bus.

Parameters:
- WIDTH, 81, width of the DUT output bus `y`.
- SIG_W, 32, signature width.
- POLY, 32'h04C11DB7, MISR feedback polynomial; bit i set = tap into bit i.
- SEED, 32'h00000000, signature value loaded on reset and on start.
- SKIP, 1, samples discarded after start (DUT settling).
- N_SAMPLES, 21, samples compacted per run.

Ports:
- clk  in  1  bench clock, rising edge active.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE and DONE only.
- y_valid  in  1  `y` is meaningful this cycle.
- y  in  WIDTH  DUT output bus.
- sig  out  SIG_W  current signature.
- sample_cnt  out  16  samples compacted in the current run.
- busy  out  1  high in WARMUP and CAPTURE.
- done  out  1  high in DONE; signature is final.
- x_seen  out  1  sticky; an accepted sample contained X or Z.

Behaviour:
- Reset (rst high at posedge): state=IDLE, sig=SEED, sample_cnt=0, busy=0, done=0, x_seen=0. Reset wins over every other input, including mid-run.
- Fold (combinational):
  - Zero-pad `y` to a multiple of SIG_W.
  - XOR all SIG_W chunks: fold = y[31:0]^y[63:32]^{15'b0,y[80:64]} at defaults.
- MISR step: sig_next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold.
- States and transitions:
  - IDLE: start -> WARMUP, or straight to CAPTURE if SKIP=0. On start: sig=SEED, sample_cnt=0, x_seen=0.
  - WARMUP: each y_valid cycle decrements the internal skip counter. No MISR update. Leaves after SKIP valid cycles.
  - CAPTURE: each y_valid cycle applies one MISR step and increments sample_cnt. When the step that makes sample_cnt==N_SAMPLES occurs, the next state is DONE.
  - DONE: sig and sample_cnt hold. start -> new run with the same reloads as IDLE.
- start is ignored in WARMUP and CAPTURE. No restart mid-run except via rst.
- y_valid low in any state: no change to sig, counters or x_seen (stall).
- Latency: sig reflects a sample at the rising edge that accepts it, i.e. visible one cycle after presentation. done asserts the cycle after the last sample's edge.
- x_seen (simulation only, excluded from synthesis):
  - Set on any accepted CAPTURE sample where the reduction-XOR of `y` is X.
  - Cleared only by rst or start.
- sample_cnt saturates at N_SAMPLES and never wraps.

Decomposition:
- Shared package `fuzz_bench_pkg`: SIG_W, default POLY and SEED, FSM state enum (IDLE, WARMUP, CAPTURE, DONE).
- One sub-module `misr_fold_step`: purely combinational fold plus MISR next-state function. Parameterised by WIDTH, SIG_W, POLY. Reused by the scoreboard model.

Test Plan:
- Zero bus: rst, start, y=0 for 1+21 valid cycles -> sig=32'h0, sample_cnt=21, done=1, x_seen=0.
- Single hit: y=1 on the first CAPTURE sample, 0 for the remaining 20 -> sig=32'h00100000 (1<<20); with N_SAMPLES=33 at final sample, MSB feedback gives sig=POLY.
- Fold aliasing: y with bits 0 and 64 set on every sample -> fold=0, sig stays SEED. y with bit 64 only, one sample, then 20 zeros -> sig=32'h00100000.
- Stall: identical stimulus to the single-hit case, y_valid deasserted for 3 cycles mid-run -> final sig identical; done is 3 cycles later.
- Reset mid-run: rst at sample 10 -> next cycle state IDLE, sig=SEED, sample_cnt=0, done=0. A subsequent full run matches a clean run bit-exactly.
- X detection: one accepted sample with y[40]=1'bx -> x_seen=1 and held through DONE; start clears it; start during CAPTURE is ignored (sample_cnt keeps counting).
